// File: rtl/button_conditioner.sv
// button_conditioner: conditions four raw push buttons for the LRU tracker.
// Each input is synchronised, debounced and edge-detected. Every press is
// stored as a sticky pending bit. The presses are then offered one at a time
// over a valid/ready handshake, and button1 has the highest priority.
//
// Ports:
//   timedClk   clock; the whole block runs in this domain
//   rst        synchronous, active-high reset
//   btn_raw    raw asynchronous buttons, bit0 = button1 .. bit3 = button4
//   out_ready  consumer accepts the offered press this cycle
//   out_valid  a press is being offered
//   out_code   button number 1..4 while out_valid, else 0
//   b1..b4     one-hot image of out_code, all 0 when out_valid is low
//   pending    sticky pending-event bits (debug / status LEDs)
//
// Optional feature: define AUTO_REPEAT_EN to re-arm pending[i] every
// REPEAT_TICKS cycles while button i stays debounced-high.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_TICKS = 8,
   parameter int unsigned REPEAT_TICKS   = 16
) (
   input  logic       timedClk,
   input  logic       rst,
   input  logic [3:0] btn_raw,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [2:0] out_code,
   output logic       b1,
   output logic       b2,
   output logic       b3,
   output logic       b4,
   output logic [3:0] pending
);

   localparam int unsigned NB = 4;
   localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);

   typedef enum logic {IDLE, OFFER} state_t;

   logic [NB-1:0] sync1, sync_s;
   logic [NB-1:0] db, db_nxt, rise, rep_set, clr, pending_nxt;
   logic [CW-1:0] cnt [NB];
   logic [CW-1:0] cnt_nxt [NB];

   state_t        state, state_nxt;
   logic [1:0]    sel, sel_nxt;
   logic          valid_nxt;
   logic [2:0]    code_nxt;
   logic [NB-1:0] onehot_q, onehot_nxt;

   // Two-flop synchroniser per button
   always_ff @(posedge timedClk) begin
      if (rst) begin
         sync1  <= '0;
         sync_s <= '0;
      end else begin
         sync1  <= btn_raw;
         sync_s <= sync1;
      end
   end

   // Debounce: db flips on the edge where the mismatch run would reach DEBOUNCE_TICKS
   always_comb begin
      db_nxt = db;
      rise   = '0;
      for (int i = 0; i < int'(NB); i++) begin
         cnt_nxt[i] = '0;
         if (sync_s[i] != db[i]) begin
            if (cnt[i] == CW'(DEBOUNCE_TICKS - 1)) begin
               db_nxt[i] = ~db[i];
               rise[i]   = ~db[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge timedClk) begin
      if (rst) begin
         db <= '0;
         for (int i = 0; i < int'(NB); i++) cnt[i] <= '0;
      end else begin
         db <= db_nxt;
         for (int i = 0; i < int'(NB); i++) cnt[i] <= cnt_nxt[i];
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);

   logic [RW-1:0] rpt [NB];
   logic [RW-1:0] rpt_nxt [NB];

   // Repeat timer runs only while db stays high; it restarts from 0 on each rise
   always_comb begin
      rep_set = '0;
      for (int i = 0; i < int'(NB); i++) begin
         rpt_nxt[i] = '0;
         if (db[i] && db_nxt[i]) begin
            if (rpt[i] == RW'(REPEAT_TICKS - 1)) begin
               rep_set[i] = 1'b1;
            end else begin
               rpt_nxt[i] = rpt[i] + RW'(1);
            end
         end
      end
   end

   always_ff @(posedge timedClk) begin
      if (rst) begin
         for (int i = 0; i < int'(NB); i++) rpt[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NB); i++) rpt[i] <= rpt_nxt[i];
      end
   end
`else
   // REPEAT_TICKS is always >= 2, so this is constant zero; there is no repeat logic
   assign rep_set = {NB{REPEAT_TICKS == 0}};
`endif

   // Arbiter next state and registered output images
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      clr       = '0;
      case (state)
         IDLE: begin
            if (|pending) begin
               state_nxt = OFFER;
               if (pending[0])      sel_nxt = 2'd0;
               else if (pending[1]) sel_nxt = 2'd1;
               else if (pending[2]) sel_nxt = 2'd2;
               else                 sel_nxt = 2'd3;
            end
         end
         OFFER: begin
            if (out_ready) begin
               clr[sel]  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      valid_nxt  = (state_nxt == OFFER);
      code_nxt   = valid_nxt ? (3'(sel_nxt) + 3'd1) : 3'd0;
      onehot_nxt = valid_nxt ? (NB'(1) << sel_nxt) : '0;
   end

   // A set on the same edge as an accept wins, so the press is offered again later
   assign pending_nxt = (pending & ~clr) | rise | rep_set;

   always_ff @(posedge timedClk) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= '0;
         pending   <= '0;
         out_valid <= 1'b0;
         out_code  <= '0;
         onehot_q  <= '0;
      end else begin
         state     <= state_nxt;
         sel       <= sel_nxt;
         pending   <= pending_nxt;
         out_valid <= valid_nxt;
         out_code  <= code_nxt;
         onehot_q  <= onehot_nxt;
      end
   end

   assign {b4, b3, b2, b1} = onehot_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner (DEBOUNCE_TICKS=4, REPEAT_TICKS=5).
// A fixed vector table covers reset and a single clean press. Hand-written
// sequences cover bounce, hold-off, priority and reset-in-offer. A random
// phase checks the design against a behavioural reference model.
module tb_button_conditioner;

   localparam int D = 4;
   localparam int R = 5;

   logic       timedClk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_raw = '0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [2:0] out_code;
   logic       b1, b2, b3, b4;
   logic [3:0] pending;

   int errors = 0;
   int checks = 0;

   button_conditioner #(.DEBOUNCE_TICKS(D), .REPEAT_TICKS(R)) dut (
      .timedClk (timedClk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_code (out_code),
      .b1       (b1),
      .b2       (b2),
      .b3       (b3),
      .b4       (b4),
      .pending  (pending)
   );

   always #5 timedClk = ~timedClk;

   // ---------------- reference model ----------------
   logic [3:0] hist[$];    // raw samples, newest first
   int         run[4];     // consecutive cycles the synced input disagreed with db
   int         rep[4];     // cycles since the last rise / repeat
   bit   [3:0] m_db;
   bit   [3:0] m_pend;
   int         m_cur;      // button index being offered, -1 when none

   function automatic int lowest(input bit [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_step(input logic [3:0] raw, input bit rdy, input bit r);
      logic [3:0] s;
      bit   [3:0] ndb, rs, rp, cl;
      int         ncur;
      if (r) begin
         hist.delete();
         for (int i = 0; i < 4; i++) begin run[i] = 0; rep[i] = 0; end
         m_db = '0; m_pend = '0; m_cur = -1;
         return;
      end
      // the synced value seen now is the raw sample from two edges back
      s = (hist.size() >= 2) ? hist[1] : 4'b0;
      hist.push_front(raw);
      while (hist.size() > 2) void'(hist.pop_back());
      ndb = m_db; rs = '0; rp = '0; cl = '0;
      for (int i = 0; i < 4; i++) begin
         if (s[i] != m_db[i]) begin
            run[i]++;
            if (run[i] == D) begin
               ndb[i] = ~m_db[i];
               rs[i]  = ndb[i];
               run[i] = 0;
            end
         end else run[i] = 0;
`ifdef AUTO_REPEAT_EN
         if (m_db[i] && ndb[i]) begin
            rep[i]++;
            if (rep[i] == R) begin rp[i] = 1'b1; rep[i] = 0; end
         end else rep[i] = 0;
`endif
      end
      ncur = m_cur;
      if (m_cur < 0) ncur = lowest(m_pend);
      else if (rdy) begin cl[m_cur] = 1'b1; ncur = -1; end
      m_pend = (m_pend & ~cl) | rs | rp;
      m_db   = ndb;
      m_cur  = ncur;
   endtask

   function automatic logic [11:0] pack_exp(input bit v, input logic [2:0] c, input logic [3:0] p);
      logic [3:0] oh;
      oh = v ? (4'b1 << (c - 3'd1)) : 4'b0;
      return {v, c, oh, p};
   endfunction

   // ---------------- drive / check helpers ----------------
   task automatic step(input logic [3:0] raw, input bit rdy, input bit r);
      btn_raw   = raw;
      out_ready = rdy;
      rst       = r;
      @(posedge timedClk);
      model_step(raw, rdy, r);
      @(negedge timedClk);
   endtask

   task automatic check_vec(input string name, input logic [11:0] exp);
      logic [11:0] act;
      act = {out_valid, out_code, b4, b3, b2, b1, pending};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got v=%0b code=%0d b4..b1=%b pend=%b, want v=%0b code=%0d b4..b1=%b pend=%b",
                  name, act[11], act[10:8], act[7:4], act[3:0], exp[11], exp[10:8], exp[7:4], exp[3:0]);
      end
   endtask

   task automatic check_model(input string name);
      check_vec(name, pack_exp(m_cur >= 0, (m_cur >= 0) ? 3'(m_cur + 1) : 3'd0, m_pend));
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // one modelled step, compared against the model
   task automatic mstep(input string name, input logic [3:0] raw, input bit rdy);
      step(raw, rdy, 1'b0);
      check_model(name);
   endtask

   typedef struct {
      logic [3:0] raw;
      bit         rdy;
      bit         r;
      bit         ev;
      logic [2:0] ec;
      logic [3:0] ep;
   } vec_t;

   vec_t tv[$];
   int   acc[$];
   int   first_valid;
   int   offers;
   bit   prev_v;
   logic [3:0] lvl;

   initial begin
      // ---- table: reset, then one clean press of button1 and its release ----
      tv.push_back('{4'b0000, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0000});
      for (int k = 1; k <= 5; k++) tv.push_back('{4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000});
      tv.push_back('{4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0001});  // edge 6: db/pending rise
      tv.push_back('{4'b0001, 1'b1, 1'b0, 1'b1, 3'd1, 4'b0001});  // edge 7: offer code 1
      tv.push_back('{4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000});  // accepted
      tv.push_back('{4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000});
      for (int k = 0; k < 8; k++) tv.push_back('{4'b0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000});
      for (int k = 0; k < tv.size(); k++) begin
         step(tv[k].raw, tv[k].rdy, tv[k].r);
         check_vec($sformatf("table[%0d]", k), pack_exp(tv[k].ev, tv[k].ec, tv[k].ep));
      end

      // ---- bounce on button2: 1,0,1,0,1 then held ----
      first_valid = -1;
      for (int k = 1; k <= 14; k++) begin
         mstep("bounce", (k == 2 || k == 4) ? 4'b0000 : 4'b0010, 1'b1);
         if (out_valid && first_valid < 0) begin
            first_valid = k;
            chk("bounce_code", int'(out_code), 2);
         end
      end
      chk("bounce_first_valid_edge", first_valid, 11);
      for (int k = 0; k < 10; k++) mstep("bounce_rel", 4'b0000, 1'b1);

      // ---- hold-off: presses 4, 3, 1 with out_ready low, no pre-emption ----
      for (int b = 0; b < 3; b++) begin
         lvl = (b == 0) ? 4'b1000 : (b == 1) ? 4'b0100 : 4'b0001;
         for (int k = 0; k < 8; k++) begin
            mstep("holdoff_press", lvl, 1'b0);
            if (out_valid) chk("holdoff_no_preempt", int'(out_code), 4);
         end
         for (int k = 0; k < 8; k++) mstep("holdoff_rel", 4'b0000, 1'b0);
      end
      chk("holdoff_pending", int'(pending), 4'b1101);
      acc.delete();
      for (int k = 0; k < 10; k++) begin
         if (out_valid) acc.push_back(int'(out_code));
         mstep("holdoff_drain", 4'b0000, 1'b1);
      end
      chk("holdoff_n_accepts", acc.size(), 3);
      if (acc.size() == 3) begin
         chk("holdoff_order0", acc[0], 4);
         chk("holdoff_order1", acc[1], 1);
         chk("holdoff_order2", acc[2], 3);
      end
      chk("holdoff_pending_end", int'(pending), 0);

      // ---- simultaneous presses of buttons 2 and 3 ----
      acc.delete();
      for (int k = 0; k < 14; k++) begin
         if (out_valid) acc.push_back(int'(out_code));
         mstep("simul", 4'b0110, 1'b1);
      end
      for (int k = 0; k < 10; k++) mstep("simul_rel", 4'b0000, 1'b1);
      chk("simul_n_accepts", acc.size(), 2);
      if (acc.size() == 2) begin
         chk("simul_first", acc[0], 2);
         chk("simul_second", acc[1], 3);
      end

      // ---- reset during an offer of code 3 with pending=0110 ----
      for (int k = 0; k < 8; k++) mstep("rstoffer_p3", 4'b0100, 1'b0);
      for (int k = 0; k < 8; k++) mstep("rstoffer_p2", 4'b0110, 1'b0);
      chk("rstoffer_code_before", int'(out_code), 3);
      chk("rstoffer_pend_before", int'(pending), 4'b0110);
      step(4'b0110, 1'b0, 1'b1);
      check_vec("rstoffer_after_rst", pack_exp(1'b0, 3'd0, 4'b0000));
      first_valid = -1;
      for (int k = 1; k <= 9; k++) begin
         mstep("rstoffer_reoffer", 4'b0110, 1'b1);
         if (out_valid && first_valid < 0) begin
            first_valid = k;
            chk("rstoffer_reoffer_code", int'(out_code), 2);
         end
      end
      chk("rstoffer_reoffer_edge", first_valid, 7);
      for (int k = 0; k < 16; k++) mstep("rstoffer_rel", 4'b0000, 1'b1);

      // ---- long hold of button1: auto-repeat count depends on the build ----
      offers = 0; prev_v = 1'b0;
      for (int k = 0; k < 40; k++) begin
         mstep("hold", (k < 18) ? 4'b0001 : 4'b0000, 1'b1);
         if (out_valid && !prev_v) offers++;
         prev_v = out_valid;
      end
`ifdef AUTO_REPEAT_EN
      chk("hold_offers", offers, 4);
`else
      chk("hold_offers", offers, 1);
`endif

      // ---- random bouncy buttons, random ready, occasional reset ----
      lvl = '0;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) lvl[i] = ~lvl[i];
         step(lvl, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
         check_model("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
